// File: rtl/batcharger_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_pkg
//  Description : Shared constants and the state encoding for the BATCHARGER
//                charge sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package batcharger_pkg;

  // Default widths and debounce depth
  localparam int c_DW_DEF   = 10;
  localparam int c_CW_DEF   = 8;
  localparam int c_TW_DEF   = 16;
  localparam int c_DEB_DEF  = 4;

  // Width of the state_o port
  localparam int c_STATE_W  = 3;

  // Charge sequencer states; the numeric values are visible on state_o
  typedef enum logic [c_STATE_W-1:0] {
    IDLE  = 3'd0,
    TC    = 3'd1,
    CC    = 3'd2,
    CV    = 3'd3,
    DONE  = 3'd4,
    FAULT = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/batcharger_timer.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_timer
//  Description : Saturating tick counter with synchronous clear and an expiry
//                compare against a programmable limit (0 = never expires).
//  Revision    : 1.0 - initial release
// ============================================================================
module batcharger_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clr,
  input  logic          i_tick,
  input  logic [TW-1:0] i_tmax,
  output logic          o_expired
);

  logic [TW-1:0] r_cnt;
  logic [TW-1:0] w_cnt_inc;

  // Count value after this cycle's tick, saturating at all-ones
  always_comb begin
    w_cnt_inc = r_cnt;
    if (i_tick && (r_cnt != '1)) begin
      w_cnt_inc = r_cnt + 1'b1;
    end
  end

  // Expiry looks at the post-tick value so the sequencer can leave on the
  // same edge the counter reaches the limit. It deliberately ignores i_clr:
  // clear is only raised when the sequencer does not act on expiry, and
  // leaving it out keeps expiry free of a path back through the next state.
  assign o_expired = (i_tmax != '0) && (w_cnt_inc == i_tmax);

  // Counter register with clear taking precedence over counting
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_inc;
    end
  end

endmodule
`default_nettype wire

// File: rtl/batcharger_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : batcharger_ctrl_seq
//  Description : Charge sequencer for the BATCHARGER power block. Walks
//                trickle -> constant-current -> constant-voltage -> done from
//                debounced ADC samples, with charge timeout, over-voltage
//                fault and automatic recharge. Outputs are registered and
//                decoded from the next state.
//  Revision    : 1.0 - initial release
// ============================================================================
module batcharger_ctrl_seq
  import batcharger_pkg::*;
#(
  parameter int DW  = c_DW_DEF,
  parameter int CW  = c_CW_DEF,
  parameter int TW  = c_TW_DEF,
  parameter int DEB = c_DEB_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 tick,
  input  logic [DW-1:0]        vbat,
  input  logic [DW-1:0]        ibat,
  input  logic                 smp_valid,
  input  logic [DW-1:0]        vtok,
  input  logic [DW-1:0]        vcutoff,
  input  logic [DW-1:0]        vpreset,
  input  logic [DW-1:0]        vovp,
  input  logic [DW-1:0]        iend,
  input  logic [TW-1:0]        tmax,
  input  logic [CW-1:0]        icc_cfg,
  input  logic [CW-1:0]        itc_cfg,
  input  logic [CW-1:0]        vcv_cfg,
  output logic                 en_o,
  output logic                 cc_o,
  output logic                 tc_o,
  output logic                 cv_o,
  output logic [CW-1:0]        icc_o,
  output logic [CW-1:0]        itc_o,
  output logic [CW-1:0]        vcv_o,
  output logic [c_STATE_W-1:0] state_o,
  output logic                 done_o,
  output logic                 fault_o
);

  localparam int                c_DEBW    = $clog2(DEB + 1);
  localparam logic [c_DEBW-1:0] c_DEB_MAX = c_DEBW'(DEB);

  state_t            r_state;
  state_t            w_nxt;
  logic [c_DEBW-1:0] r_deb;
  logic [c_DEBW-1:0] w_deb_cnt;
  logic              w_cond;
  logic              w_active;
  logic              w_ovp;
  logic              w_tmo;
  logic              w_deb_hit;
  logic              w_expired;
  logic              w_tmr_clr;
  logic              w_en_nxt;

  logic              r_en, r_cc, r_tc, r_cv, r_done, r_fault;
  logic [CW-1:0]     r_icc, r_itc, r_vcv;

  // Per-state threshold condition that the debounce counter qualifies
  always_comb begin
    w_cond = 1'b0;
    unique case (r_state)
      TC:      w_cond = (vbat >= vtok);
      CC:      w_cond = (vbat >= vcutoff);
      CV:      w_cond = (ibat <  iend);
      DONE:    w_cond = (vbat <  vpreset);
      default: w_cond = 1'b0;
    endcase
  end

  assign w_active = (r_state == TC) || (r_state == CC) || (r_state == CV);
  assign w_ovp    = w_active && smp_valid && (vbat >= vovp);
  assign w_tmo    = w_active && w_expired;

  // Debounce count after this cycle's sample: hold, clear or saturating step
  always_comb begin
    if (!smp_valid) begin
      w_deb_cnt = r_deb;
    end else if (!w_cond) begin
      w_deb_cnt = '0;
    end else if (r_deb == c_DEB_MAX) begin
      w_deb_cnt = r_deb;
    end else begin
      w_deb_cnt = r_deb + 1'b1;
    end
  end

  // Fires on the edge where the DEB-th consecutive qualifying sample lands
  assign w_deb_hit = smp_valid && w_cond && (w_deb_cnt == c_DEB_MAX);

  // Next-state selection: disable, then OVP, then timeout, then thresholds
  always_comb begin
    w_nxt = r_state;
    if (!en) begin
      w_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (smp_valid) begin
            if (vbat < vtok)         w_nxt = TC;
            else if (vbat < vcutoff) w_nxt = CC;
            else                     w_nxt = CV;
          end
        end
        TC: begin
          if (w_ovp || w_tmo)  w_nxt = FAULT;
          else if (w_deb_hit)  w_nxt = CC;
        end
        CC: begin
          if (w_ovp || w_tmo)  w_nxt = FAULT;
          else if (w_deb_hit)  w_nxt = CV;
        end
        CV: begin
          if (w_ovp)                   w_nxt = FAULT;
          else if (w_tmo || w_deb_hit) w_nxt = DONE;
        end
        DONE: begin
          if (w_deb_hit)       w_nxt = CC;
        end
        FAULT:   w_nxt = FAULT;
        default: w_nxt = IDLE;
      endcase
    end
  end

  // Timer restarts for a fresh charge (leaving IDLE, recharge from DONE) and
  // is held at zero while idle; it runs through TC -> CC -> CV unbroken.
  assign w_tmr_clr = (w_nxt == IDLE) || (r_state == IDLE) ||
                     ((r_state == DONE) && (w_nxt == CC));

  batcharger_timer #(
    .TW (TW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_tmr_clr),
    .i_tick    (tick && w_active),
    .i_tmax    (tmax),
    .o_expired (w_expired)
  );

  assign w_en_nxt = (w_nxt == TC) || (w_nxt == CC) || (w_nxt == CV);

  // State, debounce counter and output registers decoded from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_deb   <= '0;
      r_en    <= 1'b0;
      r_cc    <= 1'b0;
      r_tc    <= 1'b0;
      r_cv    <= 1'b0;
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      r_icc   <= '0;
      r_itc   <= '0;
      r_vcv   <= '0;
    end else begin
      r_state <= w_nxt;
      r_deb   <= (w_nxt != r_state) ? '0 : w_deb_cnt;
      r_en    <= w_en_nxt;
      r_cc    <= (w_nxt == CC);
      r_tc    <= (w_nxt == TC);
      r_cv    <= (w_nxt == CV);
      r_done  <= (w_nxt == DONE);
      r_fault <= (w_nxt == FAULT);
      r_icc   <= w_en_nxt ? icc_cfg : '0;
      r_itc   <= w_en_nxt ? itc_cfg : '0;
      r_vcv   <= w_en_nxt ? vcv_cfg : '0;
    end
  end

  assign state_o = r_state;
  assign en_o    = r_en;
  assign cc_o    = r_cc;
  assign tc_o    = r_tc;
  assign cv_o    = r_cv;
  assign done_o  = r_done;
  assign fault_o = r_fault;
  assign icc_o   = r_icc;
  assign itc_o   = r_itc;
  assign vcv_o   = r_vcv;

endmodule
`default_nettype wire
